pin_checker: RTL
================

Name: pin_checker

Overview:
- Reads the PIN digits that the keypad latch stage presents on a 4-bit data bus, one digit per enable strobe.
- Assembles DIGITS digits, compares them against the account PIN, and emits a one-cycle accept or reject pulse.
- Tracks remaining attempts and holds a timed lockout after MAX_TRIES consecutive failures.
- Sits between the keypad/latch front end and the ATM transaction controller.

Parameters:
WIDTH, 4, bits per digit (dataIn width)
DIGITS, 4, digits per PIN entry (>=2)
MAX_TRIES, 3, consecutive wrong entries before lockout (>=1)
LOCK_CYCLES, 16, clock cycles the lockout is held (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  digit strobe; dataIn is valid while high, one digit per high cycle
dataIn  input  WIDTH  digit value
clear  input  1  abandon the partial entry
storedPin  input  WIDTH*DIGITS  reference PIN; first-entered digit is in the MS nibble
accept  output  1  one-cycle pulse: PIN matched
reject  output  1  one-cycle pulse: PIN mismatched
locked  output  1  high while in lockout
digitCount  output  clog2(DIGITS+1)  digits captured in the current entry
triesLeft  output  clog2(MAX_TRIES+1)  remaining attempts

Behaviour:
- Reset (async, any state):
  - state ENTRY; entry buffer 0; digitCount 0; triesLeft MAX_TRIES.
  - accept, reject, locked 0; lock counter 0.
  - Reset asserted mid-entry or mid-lockout discards everything.
- States: ENTRY, CHECK, LOCKED. All outputs are registered.
- ENTRY:
  - On a rising edge with en=1 and clear=0: buffer <= {buffer[WIDTH*(DIGITS-1)-1:0], dataIn}; digitCount +1.
  - If that edge captures digit number DIGITS: next state CHECK and digitCount resets to 0.
  - clear=1 zeroes the buffer and digitCount. clear has priority over a simultaneous en, and that digit is dropped.
  - en held high for k cycles captures k digits. There is no edge detect.
- CHECK (exactly one cycle):
  - Compare buffer with storedPin, sampled in this cycle only. en and clear are ignored.
  - Match: accept=1 for the next cycle; triesLeft <= MAX_TRIES; buffer <= 0; go to ENTRY.
  - Mismatch with triesLeft>1: reject=1 for the next cycle; triesLeft -1; buffer <= 0; go to ENTRY.
  - Mismatch with triesLeft==1: reject=1 for the next cycle; triesLeft <= 0; locked <= 1; lock counter <= LOCK_CYCLES-1; go to LOCKED.
- Latency:
  - The last digit is captured at edge N.
  - CHECK occupies the cycle N..N+1.
  - accept or reject is high from edge N+1 to edge N+2.
  - A new entry may start capturing at edge N+2. en during the CHECK cycle is lost.
- LOCKED:
  - en and clear are ignored.
  - The counter decrements each cycle. On the edge where it reads 0: locked <= 0, triesLeft <= MAX_TRIES, state ENTRY.
  - locked is high for exactly LOCK_CYCLES cycles.
- accept and reject are never high together and never high for more than one consecutive cycle.
- The attempt counter never wraps below 0. A successful entry always restores MAX_TRIES.

Test Plan:
All scenarios use defaults and storedPin=16'h1234.
1. Reset: hold rst=1 for 10 ns with en=1 -> accept=0, reject=0, locked=0, digitCount=0, triesLeft=3; no capture.
2. Correct entry: strobe digits 1,2,3,4 on consecutive cycles -> digitCount steps 1,2,3 then 0; accept=1 for exactly one cycle, one cycle after the last capture; triesLeft=3.
3. Clear priority: enter 1,2; assert clear and en (dataIn=9) together; then enter 1,2,3,4 -> digitCount 2→0 on the clear edge, 9 not captured, accept=1.
4. Wrong entries: enter 5,5,5,5 twice -> reject pulses, triesLeft 3→2→1. Then enter 1,2,3,4 -> accept, triesLeft=3.
5. Lockout: three wrong entries -> third reject pulse coincides with locked=1. Digits 1,2,3,4 entered during LOCKED are ignored (no accept, digitCount=0). locked stays high exactly 16 cycles, then triesLeft=3 and 1,2,3,4 is accepted.
6. Async reset: assert rst between clock edges, mid-lockout and again after 3 digits -> outputs return to reset values immediately; the next 1,2,3,4 entry is accepted.

Source files
------------

// File: rtl/pin_checker.sv
`timescale 1ns/1ps
// pin_checker: collects DIGITS keypad digits, compares them with the account PIN and
// pulses accept/reject. Consecutive failures count down the remaining attempts; when
// they run out, further input is ignored for LOCK_CYCLES cycles.
module pin_checker #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned LOCK_CYCLES = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic [WIDTH-1:0]                  dataIn,
    input  logic                              clear,
    input  logic [WIDTH*DIGITS-1:0]           storedPin,
    output logic                              accept,
    output logic                              reject,
    output logic                              locked,
    output logic [$clog2(DIGITS+1)-1:0]       digitCount,
    output logic [$clog2(MAX_TRIES+1)-1:0]    triesLeft
);

    localparam int unsigned BW = WIDTH * DIGITS;
    localparam int unsigned CW = $clog2(DIGITS + 1);
    localparam int unsigned TW = $clog2(MAX_TRIES + 1);
    // One spare bit keeps the width non-zero when LOCK_CYCLES is 1.
    localparam int unsigned LW = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {StEntry, StCheck, StLocked} state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   buf_q, buf_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   tries_q, tries_d;
    logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
    logic            accept_q, accept_d;
    logic            reject_q, reject_d;
    logic            locked_q, locked_d;

    // Next-state logic for the entry / check / lockout sequence.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        tries_d    = tries_q;
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;
        accept_d   = 1'b0;
        reject_d   = 1'b0;

        case (state_q)
            StEntry: begin
                if (clear) begin
                    // clear wins over a simultaneous strobe; that digit is dropped.
                    buf_d = '0;
                    cnt_d = '0;
                end else if (en) begin
                    buf_d = {buf_q[BW-WIDTH-1:0], dataIn};
                    if (cnt_q == CW'(DIGITS - 1)) begin
                        cnt_d   = '0;
                        state_d = StCheck;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            StCheck: begin
                buf_d   = '0;
                state_d = StEntry;
                if (buf_q == storedPin) begin
                    accept_d = 1'b1;
                    tries_d  = TW'(MAX_TRIES);
                end else begin
                    reject_d = 1'b1;
                    if (tries_q > TW'(1)) begin
                        tries_d = tries_q - TW'(1);
                    end else begin
                        tries_d    = '0;
                        locked_d   = 1'b1;
                        lock_cnt_d = LW'(LOCK_CYCLES - 1);
                        state_d    = StLocked;
                    end
                end
            end

            StLocked: begin
                if (lock_cnt_q == '0) begin
                    locked_d = 1'b0;
                    tries_d  = TW'(MAX_TRIES);
                    state_d  = StEntry;
                end else begin
                    lock_cnt_d = lock_cnt_q - LW'(1);
                end
            end

            default: begin
                state_d = StEntry;
            end
        endcase
    end

    // State and registered outputs; reset discards any partial entry or lockout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StEntry;
            buf_q      <= '0;
            cnt_q      <= '0;
            tries_q    <= TW'(MAX_TRIES);
            lock_cnt_q <= '0;
            accept_q   <= 1'b0;
            reject_q   <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            tries_q    <= tries_d;
            lock_cnt_q <= lock_cnt_d;
            accept_q   <= accept_d;
            reject_q   <= reject_d;
            locked_q   <= locked_d;
        end
    end

    assign accept     = accept_q;
    assign reject     = reject_q;
    assign locked     = locked_q;
    assign digitCount = cnt_q;
    assign triesLeft  = tries_q;

endmodule
